// File: rtl/float_normalizer_pkg.sv
// Shared FPU datapath definitions: widths and the normalizer state encoding.
package fpu_pkg;

    localparam int MANT_W = 27;  // [26] overflow, [25] hidden, [24:2] fraction, [1] guard, [0] sticky
    localparam int FRAC_W = 23;  // stored fraction width
    localparam int EXP_W  = 9;   // biased exponent with one bit of overflow headroom

    typedef enum logic [2:0] {
        IDLE,
        RSHIFT,
        LSHIFT,
        ROUND,
        DONE
    } norm_state_t;

endpackage

// File: rtl/float_normalizer_rne_rounder.sv
// Round-to-nearest-even on a 23-bit fraction with guard and sticky bits.
// The carry flags a fraction wrap from all ones to zero.
module rne_rounder
    import fpu_pkg::*;
(
    input  logic [FRAC_W-1:0] frac,
    input  logic              guard,
    input  logic              sticky,
    output logic [FRAC_W-1:0] frac_rnd,
    output logic              carry
);

    logic            w_rnd_up;
    logic [FRAC_W:0] w_sum;

    // Round up when above half, or exactly half with an odd fraction.
    assign w_rnd_up = guard & (sticky | frac[0]);
    assign w_sum    = {1'b0, frac} + {{FRAC_W{1'b0}}, w_rnd_up};
    assign frac_rnd = w_sum[FRAC_W-1:0];
    assign carry    = w_sum[FRAC_W];

endmodule

// File: rtl/float_normalizer.sv
// Post-arithmetic normalize-and-round stage. Normalizes the extended
// mantissa one bit per clock, rounds to nearest-even and presents the
// pre-carry exponent, rounding carry, fraction and sign for one DONE cycle.
// A mantissa that is already normalized in LSHIFT is rounded on the same
// transition into DONE; ROUND is only visited after a right shift.
module float_normalizer
    import fpu_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              sign_in,
    input  logic [EXP_W-1:0]  exp_in,
    input  logic [MANT_W-1:0] mant_in,
    output logic              busy,
    output logic              done,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic              up,
    output logic [FRAC_W-1:0] frac_out
);

    localparam logic [EXP_W-1:0] EXP_MAX = '1;
    localparam logic [EXP_W-1:0] EXP_ONE = EXP_W'(1);

    norm_state_t       r_state;
    logic              r_sign;
    logic [EXP_W-1:0]  r_exp;
    logic [MANT_W-1:0] r_mant;

    logic [FRAC_W-1:0] w_frac_rnd;
    logic              w_carry;

    rne_rounder u_rnd (
        .frac     (r_mant[FRAC_W+1:2]),
        .guard    (r_mant[1]),
        .sticky   (r_mant[0]),
        .frac_rnd (w_frac_rnd),
        .carry    (w_carry)
    );

    // Control FSM with working registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state  <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            sign_out <= 1'b0;
            exp_out  <= '0;
            up       <= 1'b0;
            frac_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_sign <= sign_in;
                        r_exp  <= exp_in;
                        r_mant <= mant_in;
                        busy   <= 1'b1;
                        if (exp_in == '0 || mant_in == '0) begin
                            r_state  <= DONE;
                            done     <= 1'b1;
                            sign_out <= sign_in;
                            exp_out  <= '0;
                            up       <= 1'b0;
                            frac_out <= '0;
                        end else if (mant_in[MANT_W-1]) begin
                            r_state <= RSHIFT;
                        end else begin
                            r_state <= LSHIFT;
                        end
                    end
                end
                RSHIFT: begin
                    // Shift right once, folding the dropped bit into sticky.
                    r_mant  <= {1'b0, r_mant[MANT_W-1:2], r_mant[1] | r_mant[0]};
                    r_exp   <= (r_exp == EXP_MAX) ? EXP_MAX : r_exp + EXP_ONE;
                    r_state <= ROUND;
                end
                LSHIFT: begin
                    if (r_mant[MANT_W-2]) begin
                        r_state  <= DONE;
                        done     <= 1'b1;
                        sign_out <= r_sign;
                        exp_out  <= r_exp;
                        up       <= w_carry;
                        frac_out <= w_frac_rnd;
                    end else if (r_exp <= EXP_ONE) begin
                        // No denormals: underflow flushes to zero.
                        r_state  <= DONE;
                        done     <= 1'b1;
                        sign_out <= r_sign;
                        exp_out  <= '0;
                        up       <= 1'b0;
                        frac_out <= '0;
                    end else begin
                        r_mant <= {r_mant[MANT_W-2:0], 1'b0};
                        r_exp  <= r_exp - EXP_ONE;
                    end
                end
                ROUND: begin
                    r_state  <= DONE;
                    done     <= 1'b1;
                    sign_out <= r_sign;
                    exp_out  <= r_exp;
                    up       <= w_carry;
                    frac_out <= w_frac_rnd;
                end
                DONE: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    done    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_float_normalizer.sv
// Directed bench for float_normalizer: vector table plus control sequences.
module tb_float_normalizer;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        sign_in;
    logic [8:0]  exp_in;
    logic [26:0] mant_in;
    logic        busy;
    logic        done;
    logic        sign_out;
    logic [8:0]  exp_out;
    logic        up;
    logic [22:0] frac_out;

    int errors = 0;
    int checks = 0;

    float_normalizer dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .sign_in  (sign_in),
        .exp_in   (exp_in),
        .mant_in  (mant_in),
        .busy     (busy),
        .done     (done),
        .sign_out (sign_out),
        .exp_out  (exp_out),
        .up       (up),
        .frac_out (frac_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sign;
        logic [8:0]  exp;
        logic [26:0] mant;
        int          lat;
        logic [8:0]  e_exp;
        logic        e_up;
        logic [22:0] e_frac;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Issue one operation; optionally pulse start again at cycle 'poke'.
    task automatic do_op(input logic s, input logic [8:0] e, input logic [26:0] m,
                         input int poke, output int lat);
        @(negedge clk);
        sign_in = s; exp_in = e; mant_in = m; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (lat == poke) begin
                start = 1'b1; sign_in = ~s; exp_in = 9'd5; mant_in = 27'h2000000;
            end
            @(posedge clk); #1;
            start = 1'b0;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int dcount;

        vecs.push_back('{"normal",      1'b0, 9'd127,  27'h2000000,  2, 9'd127,  1'b0, 23'h000000});
        vecs.push_back('{"ovf",         1'b0, 9'd127,  27'h4000000,  3, 9'd128,  1'b0, 23'h000000});
        vecs.push_back('{"ovf_clamp",   1'b1, 9'h1FF,  27'h4000000,  3, 9'h1FF,  1'b0, 23'h000000});
        vecs.push_back('{"lshift2",     1'b0, 9'd10,   27'h0800000,  4, 9'd8,    1'b0, 23'h000000});
        vecs.push_back('{"lshift25",    1'b1, 9'd100,  27'h0000001, 27, 9'd75,   1'b0, 23'h000000});
        vecs.push_back('{"rnd_carry",   1'b0, 9'd127,  27'h3FFFFFE,  2, 9'd127,  1'b1, 23'h000000});
        vecs.push_back('{"tie_even",    1'b0, 9'd127,  27'h2000002,  2, 9'd127,  1'b0, 23'h000000});
        vecs.push_back('{"tie_odd",     1'b0, 9'd127,  27'h2000006,  2, 9'd127,  1'b0, 23'h000002});
        vecs.push_back('{"rnd_sticky",  1'b1, 9'd50,   27'h3000003,  2, 9'd50,   1'b0, 23'h400001});
        vecs.push_back('{"zero_mant",   1'b1, 9'd127,  27'h0000000,  1, 9'd0,    1'b0, 23'h000000});
        vecs.push_back('{"zero_exp",    1'b0, 9'd0,    27'h2ABCDEF,  1, 9'd0,    1'b0, 23'h000000});
        vecs.push_back('{"flush",       1'b0, 9'd3,    27'h0000004,  4, 9'd0,    1'b0, 23'h000000});

        n_rst = 1'b0; start = 1'b0; sign_in = 1'b0; exp_in = '0; mant_in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_outs", {8'd0, sign_out, exp_out, up, frac_out}, 32'd0);
        n_rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i].sign, vecs[i].exp, vecs[i].mant, 0, lat);
            chk({vecs[i].name, "_lat"},  32'(lat),      32'(vecs[i].lat));
            chk({vecs[i].name, "_busy"}, 32'(busy),     32'd1);
            chk({vecs[i].name, "_sign"}, 32'(sign_out), 32'(vecs[i].sign));
            chk({vecs[i].name, "_exp"},  32'(exp_out),  32'(vecs[i].e_exp));
            chk({vecs[i].name, "_up"},   32'(up),       32'(vecs[i].e_up));
            chk({vecs[i].name, "_frac"}, 32'(frac_out), 32'(vecs[i].e_frac));
            @(posedge clk); #1;
            chk({vecs[i].name, "_done_pulse"}, 32'(done), 32'd0);
            chk({vecs[i].name, "_busy_fall"},  32'(busy), 32'd0);
            chk({vecs[i].name, "_hold_exp"},   32'(exp_out), 32'(vecs[i].e_exp));
        end

        // A start pulse in the middle of left shifting must be ignored.
        do_op(1'b0, 9'd100, 27'h0000001, 4, lat);
        chk("ign_lat",  32'(lat),      32'd27);
        chk("ign_exp",  32'(exp_out),  32'd75);
        chk("ign_sign", 32'(sign_out), 32'd0);
        @(posedge clk); #1;

        // Leave a nonzero result, then reset during LSHIFT.
        do_op(1'b1, 9'd127, 27'h2000006, 0, lat);
        @(posedge clk); #1;
        chk("pre_rst_exp", 32'(exp_out), 32'd127);
        @(negedge clk);
        sign_in = 1'b1; exp_in = 9'd100; mant_in = 27'h0000001; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_busy", 32'(busy), 32'd1);
        n_rst = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_outs", {8'd0, sign_out, exp_out, up, frac_out}, 32'd0);
        dcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("abort_no_done", 32'(dcount), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
